// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a bulk-organised FIFO one bulk at a time onto a valid/ready stream.
//   clk               system clock, also the FIFO read clock
//   rst_n             asynchronous active-low reset
//   enable            allows a new bulk to start (sampled only while idle)
//   fifo_r_ready      FIFO holds at least one full bulk
//   fifo_error_empty  FIFO empty flag
//   fifo_r_enable     FIFO read strobe, one word per high cycle
//   fifo_rdata        FIFO read data, valid one cycle after the strobe
//   m_tdata/m_tvalid/m_tready/m_tlast  output stream, m_tlast on the final beat of a bulk
//   busy              high while a bulk is being read or flushed
//   burst_count       completed bulks, wraps
//   underflow         sticky: a read was issued while the FIFO reported empty
module fifo_burst_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int BULK_OF_DATA = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_r_ready,
    input  logic                  fifo_error_empty,
    output logic                  fifo_r_enable,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic [31:0]           burst_count,
    output logic                  underflow
);
    localparam int CW = $clog2(BULK_OF_DATA + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_issued;
    logic                  r_in_flight;
    logic                  r_in_last;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_l0;
    logic                  r_l1;
    logic [1:0]            r_count;
    logic [31:0]           r_bursts;
    logic                  r_underflow;

    logic       w_pop;
    logic       w_push;
    logic       w_rd;
    logic       w_last_rd;
    logic [1:0] w_room;

    assign w_pop     = (r_count != 2'd0) && m_tready;
    assign w_push    = r_in_flight;
    // Queue occupancy after this cycle including the word still in flight;
    // a new read is only issued if it is guaranteed a slot.
    assign w_room    = r_count + {1'b0, r_in_flight} - {1'b0, w_pop};
    assign w_rd      = (r_state == S_BURST) && (r_issued < CW'(BULK_OF_DATA)) && (w_room < 2'd2);
    assign w_last_rd = w_rd && (r_issued == CW'(BULK_OF_DATA - 1));

    assign fifo_r_enable = w_rd;
    assign m_tdata       = r_d0;
    assign m_tlast       = r_l0;
    assign m_tvalid      = r_count != 2'd0;
    assign busy          = r_state != S_IDLE;
    assign burst_count   = r_bursts;
    assign underflow     = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_issued    <= '0;
            r_in_flight <= 1'b0;
            r_in_last   <= 1'b0;
            r_bursts    <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_in_flight <= w_rd;
            r_in_last   <= w_last_rd;
            if (w_rd && fifo_error_empty)
                r_underflow <= 1'b1;
            if (r_state == S_IDLE) begin
                r_issued <= '0;
                if (enable && fifo_r_ready)
                    r_state <= S_BURST;
            end else if (r_state == S_BURST) begin
                if (w_rd)
                    r_issued <= r_issued + CW'(1);
                if (w_last_rd)
                    r_state <= S_FLUSH;
            end else if (r_state == S_FLUSH) begin
                if (w_pop && r_l0) begin
                    r_state  <= S_IDLE;
                    r_bursts <= r_bursts + 32'd1;
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    // Two-entry queue, entry 0 is the head; entries only move on a pop so the
    // head is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0    <= '0;
            r_d1    <= '0;
            r_l0    <= 1'b0;
            r_l1    <= 1'b0;
            r_count <= 2'd0;
        end else if (w_push && w_pop) begin
            if (r_count == 2'd1) begin
                r_d0 <= fifo_rdata;
                r_l0 <= r_in_last;
            end else begin
                r_d0 <= r_d1;
                r_l0 <= r_l1;
                r_d1 <= fifo_rdata;
                r_l1 <= r_in_last;
            end
        end else if (w_pop) begin
            r_d0    <= r_d1;
            r_l0    <= r_l1;
            r_count <= r_count - 2'd1;
        end else if (w_push) begin
            if (r_count == 2'd0) begin
                r_d0 <= fifo_rdata;
                r_l0 <= r_in_last;
            end else begin
                r_d1 <= fifo_rdata;
                r_l1 <= r_in_last;
            end
            r_count <= r_count + 2'd1;
        end
    end
endmodule
